// File: rtl/uart_pkg.sv
// Constants and types shared by the UART receive and transmit paths.
// The frame is one start bit, DATA_BITS data bits LSB first, then one stop bit.
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam int   FRAME_BITS = 10;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Pin-side input and byte-side outputs of the UART receiver.
// rx_valid and frame_error are single-cycle strobes with no back-pressure.
// rx_data is meaningful whenever rx_valid is high and holds until the next good frame.
interface uart_rx_if;
  import uart_pkg::*;

  logic      rx_in;
  logic [7:0] rx_data;
  logic      rx_valid;
  logic      frame_error;
  logic      busy;
  rx_state_t state;

  modport master (
    input  rx_in,
    output rx_data, rx_valid, frame_error, busy, state
  );

  modport slave (
    output rx_in,
    input  rx_data, rx_valid, frame_error, busy, state
  );
endinterface

// File: rtl/sync_2ff.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Flops reset to 1 so an idle-high line is not mistaken for activity.
module sync_2ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sr <= '1;
    else       sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit recheck at half a bit, then data and stop
// sampled at bit mid-points. A low stop bit flags a framing error and waits out the break.
module uart_rx
  import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input logic      clk,
    input logic      reset,
    uart_rx_if.master bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 8) begin : g_bad_cpb
      $error("uart_rx: CLKS_PER_BIT must be >= 8");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("uart_rx: SYNC_STAGES must be >= 2");
    end
  endgenerate

  logic rx_s;

  sync_2ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.rx_in),
    .q     (rx_s)
  );

  rx_state_t            state, state_n;
  logic [CNT_W-1:0]     clk_cnt, clk_cnt_n;
  logic [IDX_W-1:0]     bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_n;
  logic                 rx_valid_q, rx_valid_n;
  logic                 frame_error_q, frame_error_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      clk_cnt       <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state         <= state_n;
      clk_cnt       <= clk_cnt_n;
      bit_idx       <= bit_idx_n;
      shift_reg     <= shift_n;
      rx_data_q     <= rx_data_n;
      rx_valid_q    <= rx_valid_n;
      frame_error_q <= frame_error_n;
    end
  end

  always_comb begin
    state_n       = state;
    clk_cnt_n     = clk_cnt;
    bit_idx_n     = bit_idx;
    shift_n       = shift_reg;
    rx_data_n     = rx_data_q;
    rx_valid_n    = 1'b0;
    frame_error_n = 1'b0;

    unique case (state)
      IDLE: begin
        clk_cnt_n = '0;
        if (rx_s == START_BIT) state_n = START;
      end

      // Recheck at half a bit so short glitches never start a frame.
      START: begin
        if (clk_cnt == CNT_HALF) begin
          clk_cnt_n = '0;
          bit_idx_n = '0;
          state_n   = (rx_s == START_BIT) ? DATA : IDLE;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end

      DATA: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_n          = '0;
          shift_n[bit_idx]   = rx_s;
          if (bit_idx == IDX_LAST) state_n   = STOP;
          else                     bit_idx_n = bit_idx + 1'b1;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end

      STOP: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_n = '0;
          if (rx_s == STOP_BIT) begin
            rx_data_n  = shift_reg;
            rx_valid_n = 1'b1;
            state_n    = IDLE;
          end else begin
            frame_error_n = 1'b1;
            state_n       = BREAK;
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end

      // A held-low line must go high before another start bit is accepted.
      BREAK: begin
        if (rx_s == STOP_BIT) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.frame_error = frame_error_q;
  assign bus.busy        = (state == DATA) || (state == STOP) || (state == BREAK);
  assign bus.state       = state;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized and directed frames driven onto rx_in, checked against a byte-level
// model (expected-byte queue, error and strobe counts, timing windows).
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  uart_rx_if u_if ();

  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  int n_checks = 0, n_fail = 0;
  int valid_cnt = 0, ferr_cnt = 0;
  int exp_valid = 0, exp_ferr = 0;
  int valid_cyc[$];
  int fall_cyc = 0;
  logic prev_strobe = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (!reset) begin
      if (u_if.rx_valid && u_if.frame_error) check("valid_ferr_excl", 1, 0);
      if (prev_strobe && (u_if.rx_valid || u_if.frame_error)) check("strobe_width", 1, 0);
      if (u_if.rx_valid) begin
        valid_cnt++;
        valid_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {24'h0, u_if.rx_data}, 32'hffff_ffff);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", {24'h0, u_if.rx_data}, {24'h0, e});
          last_good = e;
        end
      end
      if (u_if.frame_error) begin
        ferr_cnt++;
        check("data_hold_on_ferr", {24'h0, u_if.rx_data}, {24'h0, last_good});
      end
      prev_strobe = u_if.rx_valid | u_if.frame_error;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  // drivers (called on a falling clock edge)
  task automatic drive_bit(input logic v, input int n);
    u_if.rx_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic skew);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    if (stop) begin
      exp_q.push_back(b);
      exp_valid++;
    end else begin
      exp_ferr++;
    end
    fall_cyc = cyc;
    for (int i = 0; i < 10; i++) drive_bit(f[i], CPB + ((skew && (i % 2 == 1)) ? 1 : 0));
  endtask

  task automatic wait_valids(input int n, input int budget);
    int t;
    t = 0;
    while (valid_cnt < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("valid_wait", (valid_cnt >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"}, {24'h0, u_if.rx_data}, 32'h0);
    check({tag, "_rx_valid"}, {31'h0, u_if.rx_valid}, 32'h0);
    check({tag, "_ferr"}, {31'h0, u_if.frame_error}, 32'h0);
    check({tag, "_busy"}, {31'h0, u_if.busy}, 32'h0);
    check({tag, "_state"}, {29'h0, u_if.state}, {29'h0, IDLE});
  endtask

  initial begin
    int lat, diff, ferr_base;
    logic busy_or;
    logic [7:0] prior, b;
    logic stop;

    u_if.rx_in = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // single good frame: data, latency, busy window
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        repeat (5) @(negedge clk);
        check("busy_before_accept", {31'h0, u_if.busy}, 32'h0);
        repeat (15) @(negedge clk);
        check("busy_in_frame", {31'h0, u_if.busy}, 32'h1);
        repeat (120) @(negedge clk);
        check("busy_late_frame", {31'h0, u_if.busy}, 32'h1);
      end
    join
    wait_valids(exp_valid, 50);
    lat = valid_cyc[valid_cyc.size()-1] - fall_cyc - 1;
    check("latency", (lat >= 153 && lat <= 155) ? 32'd154 : lat, 32'd154);
    check("busy_after_frame", {31'h0, u_if.busy}, 32'h0);
    check("a5_ferr_count", ferr_cnt, 0);

    // back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    drive_bit(1'b1, 4);
    wait_valids(exp_valid, 50);
    diff = valid_cyc[valid_cyc.size()-1] - valid_cyc[valid_cyc.size()-2];
    check("b2b_spacing", (diff >= 159 && diff <= 161) ? 32'd160 : diff, 32'd160);

    // 3-cycle glitch on the idle line
    busy_or = 1'b0;
    u_if.rx_in = 1'b0;
    repeat (3) begin @(negedge clk); busy_or |= u_if.busy; end
    u_if.rx_in = 1'b1;
    repeat (12) begin @(negedge clk); busy_or |= u_if.busy; end
    check("glitch_busy", {31'h0, busy_or}, 32'h0);
    check("glitch_state", {29'h0, u_if.state}, {29'h0, IDLE});
    check("glitch_valid_count", valid_cnt, exp_valid);
    check("glitch_ferr_count", ferr_cnt, exp_ferr);

    // bad stop bit followed by a held-low break, then a good frame
    prior = last_good;
    ferr_base = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    drive_bit(1'b0, 40);
    check("break_busy", {31'h0, u_if.busy}, 32'h1);
    check("break_state", {29'h0, u_if.state}, {29'h0, BREAK});
    check("break_ferr_once", ferr_cnt - ferr_base, 1);
    drive_bit(1'b1, 32);
    check("after_break_state", {29'h0, u_if.state}, {29'h0, IDLE});
    check("after_break_data", {24'h0, u_if.rx_data}, {24'h0, prior});
    check("after_break_valid_count", valid_cnt, exp_valid);
    send_frame(8'h81, 1'b1, 1'b0);
    wait_valids(exp_valid, 50);

    // reset during data bit 4 of 8'h5A
    drive_bit(1'b0, CPB);
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b1, CPB / 2);
    reset = 1'b1;
    last_good = 8'h00;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(negedge clk);
    reset = 1'b0;
    drive_bit(1'b1, 60);
    check("post_reset_data", {24'h0, u_if.rx_data}, 32'h0);
    check("post_reset_valid_count", valid_cnt, exp_valid);
    send_frame(8'h77, 1'b1, 1'b0);
    wait_valids(exp_valid, 50);

    // slow transmitter: alternating 16/17-cycle bits
    send_frame(8'hC3, 1'b1, 1'b1);
    wait_valids(exp_valid, 50);

    // random frames, mostly good, random idle gaps
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop, 1'b0);
      if (stop) drive_bit(1'b1, $urandom_range(0, 20));
      else      drive_bit(1'b1, $urandom_range(4, 20));
    end
    drive_bit(1'b1, 20);
    wait_valids(exp_valid, 50);

    check("final_queue_empty", exp_q.size(), 0);
    check("final_valid_count", valid_cnt, exp_valid);
    check("final_ferr_count", ferr_cnt, exp_ferr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
